mux8_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 8:1 operand/field mux (3-bit select).
//  Up to 8 requesters compete for the mux. The block grants one at a time and drives the
//  mux select from a register. It bounds each tenure with a hold limit so that no

---
 rtl/mux8_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 mux. Grants one requester at a time,
// drives the registered mux select, and bounds each tenure with a hold limit.
module mux8_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [3:0]       hold_cnt
);

  localparam logic       LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [3:0] HOLD_LAST = (MAX_HOLD == 0) ? 4'd15 : 4'(MAX_HOLD - 1);
  localparam logic [3:0] HOLD_SAT  = 4'd15;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [3:0]       hold_q, hold_d;

  logic             owner_req_s;
  logic             release_s;
  logic [N_REQ-1:0] cand_s;
  logic [SEL_W-1:0] next_ptr_s;
  logic [SEL_W-1:0] win_idle_s;
  logic [SEL_W-1:0] win_hand_s;

  // First set bit of mask scanning from ptr upwards, wrapping 7 -> 0.
  function automatic logic [SEL_W-1:0] pick(input logic [SEL_W-1:0] ptr,
                                            input logic [N_REQ-1:0] mask);
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] one;
    one    = {{(N_REQ-1){1'b0}}, 1'b1};
    onehot = one << idx;
  endfunction

  // Release and candidate decode for the current owner.
  always_comb begin
    owner_req_s = req[sel_q];
    cand_s      = req & ~onehot(sel_q);
    next_ptr_s  = sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
    release_s   = !owner_req_s || (LIMIT_EN && (hold_q == HOLD_LAST));
    win_idle_s  = pick(ptr_q, req);
    win_hand_s  = pick(next_ptr_s, cand_s);
  end

  // Next-state logic for the grant FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (arb_en && (|req)) begin
          state_d = GRANT;
          gnt_d   = onehot(win_idle_s);
          sel_d   = win_idle_s;
          hold_d  = 4'd0;
        end else begin
          gnt_d  = {N_REQ{1'b0}};
          hold_d = 4'd0;
        end
      end
      GRANT: begin
        if (!release_s) begin
          if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 4'd1;
          end else begin
            hold_d = hold_q;
          end
        end else begin
          ptr_d = next_ptr_s;
          if (arb_en && (|cand_s)) begin
            // Back-to-back handover: no idle cycle between owners.
            gnt_d  = onehot(win_hand_s);
            sel_d  = win_hand_s;
            hold_d = 4'd0;
          end else if (arb_en && owner_req_s) begin
            hold_d = 4'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = {N_REQ{1'b0}};
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N_REQ{1'b0}};
        hold_d  = 4'd0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= {SEL_W{1'b0}};
      gnt_q   <= {N_REQ{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      busy_q  <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scenario bench for mux8_rr_arbiter: expected outputs are queued as stimulus is applied
// and compared after the following clock edge.
module tb_mux8_rr_arbiter;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       arb_en = 1'b0;
  logic [7:0] req    = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic [3:0] hold_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic [3:0] hold;
    logic       hchk;
  } exp_t;

  exp_t sb[$];

  mux8_rr_arbiter #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] s, input logic b,
                      input logic [3:0] h, input logic hc);
    exp_t e;
    e.gnt = g; e.sel = s; e.busy = b; e.hold = h; e.hchk = hc;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n  = 1'b0;
    req    = r;
    arb_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    req = 8'hFF; arb_en = 1'b1; rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push(8'h00, 3'd0, 1'b0, 4'd0, 1'b1);
      if (k == 0) #1; else tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, hold_cnt} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL reset step%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 k, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] rq [3] = '{8'h08, 8'h00, 8'h00};
    logic [7:0] eg [3] = '{8'h08, 8'h00, 8'h00};
    logic       eb [3] = '{1'b1, 1'b0, 1'b0};
    exp_t e;
    do_reset(8'h00);
    for (int k = 0; k < 3; k++) begin
      req = rq[k];
      push(eg[k], 3'd3, eb[k], 4'd0, eb[k]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, (e.hchk ? hold_cnt : 4'd0)} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL single step%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 k, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] one = 8'h01;
    int o;
    exp_t e;
    do_reset(8'hFF);
    for (int c = 0; c < 36; c++) begin
      o = (c / 4) % 8;
      push(one << o, 3'(o), 1'b1, 4'(c % 4), 1'b1);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, hold_cnt} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL fairness cyc%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 c, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  task automatic test_pointer();
    logic [7:0] rq [5] = '{8'h04, 8'h00, 8'h24, 8'h04, 8'h00};
    logic [7:0] eg [5] = '{8'h04, 8'h00, 8'h20, 8'h04, 8'h00};
    logic [2:0] es [5] = '{3'd2, 3'd2, 3'd5, 3'd2, 3'd2};
    logic       eb [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e;
    do_reset(8'h00);
    for (int k = 0; k < 5; k++) begin
      req = rq[k];
      push(eg[k], es[k], eb[k], 4'd0, eb[k]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, (e.hchk ? hold_cnt : 4'd0)} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL pointer step%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 k, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] rq [4] = '{8'h80, 8'hC1, 8'h41, 8'h00};
    logic [7:0] eg [4] = '{8'h80, 8'h80, 8'h01, 8'h00};
    logic [2:0] es [4] = '{3'd7, 3'd7, 3'd0, 3'd0};
    logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] eh [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
    exp_t e;
    do_reset(8'h00);
    for (int k = 0; k < 4; k++) begin
      req = rq[k];
      push(eg[k], es[k], eb[k], eh[k], eb[k]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, (e.hchk ? hold_cnt : 4'd0)} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL wrap step%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 k, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  task automatic test_regrant_and_enable();
    logic act;
    exp_t e;
    do_reset(8'h00);
    req = 8'h02;
    for (int c = 0; c < 17; c++) begin
      if (c == 10) arb_en = 1'b0;
      if (c == 16) arb_en = 1'b1;
      act = (c < 12) || (c == 16);
      push(act ? 8'h02 : 8'h00, 3'd1, act, (c == 16) ? 4'd0 : 4'(c % 4), act);
      tick();
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, (e.hchk ? hold_cnt : 4'd0)} !== {e.gnt, e.sel, e.busy, (e.hchk ? e.hold : 4'd0)}) begin
        failures++;
        $display("FAIL regrant cyc%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 c, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rq [5] = '{8'h40, 8'h00, 8'h40, 8'h40, 8'h40};
    logic [7:0] eg [5] = '{8'h40, 8'h00, 8'h40, 8'h40, 8'h40};
    logic [3:0] eh [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    logic       eb [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    do_reset(8'h00);
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        req = rq[k];
        push(eg[k], 3'd6, eb[k], eh[k], eb[k]);
        tick();
      end else if (k == 5) begin
        #2;
        rst_n = 1'b0;
        push(8'h00, 3'd0, 1'b0, 4'd0, 1'b1);
        #1;
      end else begin
        req   = 8'hC0;
        rst_n = 1'b1;
        push(8'h40, 3'd6, 1'b1, 4'd0, 1'b1);
        tick();
      end
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, (e.hchk ? hold_cnt : 4'd0)} !== {e.gnt, e.sel, e.busy, e.hold}) begin
        failures++;
        $display("FAIL async_reset step%0d act gnt=%h sel=%0d busy=%b hold=%0d exp gnt=%h sel=%0d busy=%b hold=%0d",
                 k, gnt, sel, busy, hold_cnt, e.gnt, e.sel, e.busy, e.hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_pointer();
    test_wrap();
    test_regrant_and_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
